// File: rtl/nunchuk_reader.sv
// nunchuk_reader: I2C master that initialises a Wii Nunchuk and polls it.
//
// Bus sequence: write F0 55, gap, write FB 00, then forever
// { gap, write 00, gap, read 6 bytes, update outputs }.
// A missing slave ACK aborts with a STOP and re-runs the FB 00 write.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   scl_oe, sda_oe      open-drain enables (1 = pull line low)
//   sda_in              synchronized SDA level
//   stick_x, stick_y    joystick bytes 0 and 1
//   z, c                buttons, active-high
//   accel_x/y/z         10-bit accelerometer values
//   data_valid          one-cycle pulse when the outputs update
//   nack_err            missing ACK seen; cleared by the next good poll
//   busy                a bus transaction is in progress
//
// Build option: define NUNCHUK_ACCEL_EN to decode the accelerometer.
// Without it the accel_* outputs are tied to zero and bytes 2-4 are
// clocked in and ACKed but not stored.
//
// Handshake: data_valid is a single-cycle qualifier with no back-pressure;
// the decoded outputs are stable from the data_valid cycle until the next
// data_valid pulse.
module nunchuk_reader #(
  parameter int         CLK_DIV  = 125,
  parameter int         POLL_GAP = 50000,
  parameter logic [6:0] DEV_ADDR = 7'h52
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic [7:0] stick_x,
  output logic [7:0] stick_y,
  output logic       z,
  output logic       c,
  output logic [9:0] accel_x,
  output logic [9:0] accel_y,
  output logic [9:0] accel_z,
  output logic       data_valid,
  output logic       nack_err,
  output logic       busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_RESET, S_INIT1, S_GAP_I, S_INIT2, S_GAP_P, S_CONV, S_GAP_R, S_READ, S_UPDATE
  } seq_e;

  typedef enum logic [2:0] {
    E_IDLE, E_START, E_SEND, E_GACK, E_RECV, E_SACK, E_STOP
  } eng_e;

  // Byte idx of the write transaction issued in sequencer state s.
  function automatic logic [7:0] tx_byte(input seq_e s, input logic [2:0] idx);
    logic [7:0] b;
    b = {DEV_ADDR, 1'b0};
    if (s == S_READ)         b = {DEV_ADDR, 1'b1};
    else if (idx == 3'd1)    b = (s == S_INIT1) ? 8'hF0 : (s == S_INIT2) ? 8'hFB : 8'h00;
    else if (idx == 3'd2)    b = (s == S_INIT1) ? 8'h55 : 8'h00;
    return b;
  endfunction

  function automatic logic [2:0] last_idx(input seq_e s);
    logic [2:0] n;
    n = 3'd0;
    if (s == S_INIT1 || s == S_INIT2) n = 3'd2;
    else if (s == S_CONV)             n = 3'd1;
    return n;
  endfunction

  seq_e seq_q, seq_d;
  eng_e eng_q, eng_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [7:0] sh_q, sh_d;
  logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic abort_q, abort_d, nack_err_q, nack_err_d, dv_q, dv_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, sx_q, sx_d, sy_q, sy_d;
  logic [1:0] b5lo_q, b5lo_d;
  logic z_q, z_d, c_q, c_d;
`ifdef NUNCHUK_ACCEL_EN
  logic [7:0] b2_q, b2_d, b3_q, b3_d, b4_q, b4_d;
  logic [5:0] b5hi_q, b5hi_d;
  logic [9:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
`endif
  logic tick, done, launch, store;
  seq_e launch_seq;

  always_comb begin
    seq_d = seq_q; eng_d = eng_q; gap_d = gap_q; ph_d = ph_q;
    bit_d = bit_q; byte_d = byte_q; sh_d = sh_q;
    scl_oe_d = scl_oe_q; sda_oe_d = sda_oe_q; busy_d = busy_q;
    abort_d = abort_q; nack_err_d = nack_err_q; dv_d = 1'b0;
    b0_d = b0_q; b1_d = b1_q; b5lo_d = b5lo_q;
    sx_d = sx_q; sy_d = sy_q; z_d = z_q; c_d = c_q;
`ifdef NUNCHUK_ACCEL_EN
    b2_d = b2_q; b3_d = b3_q; b4_d = b4_q; b5hi_d = b5hi_q;
    ax_d = ax_q; ay_d = ay_q; az_d = az_q;
`endif
    done = 1'b0; launch = 1'b0; store = 1'b0; launch_seq = S_INIT1;
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;

    // Bit engine: one action per quarter tick, phase 0..3 within each bit.
    if (tick) begin
      ph_d = ph_q + 2'd1;
      case (eng_q)
        E_START: begin
          if (ph_q == 2'd0) sda_oe_d = 1'b1;
          else begin scl_oe_d = 1'b1; eng_d = E_SEND; ph_d = 2'd0; end
        end
        E_SEND: begin
          case (ph_q)
            2'd0: sda_oe_d = ~sh_q[7];
            2'd1: scl_oe_d = 1'b0;
            2'd2: ;
            default: begin
              scl_oe_d = 1'b1;
              sh_d = {sh_q[6:0], 1'b0};
              if (bit_q == 3'd0) eng_d = E_GACK;
              else bit_d = bit_q - 3'd1;
            end
          endcase
        end
        E_GACK: begin
          case (ph_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: if (sda_in) begin abort_d = 1'b1; nack_err_d = 1'b1; end
            default: begin
              scl_oe_d = 1'b1;
              bit_d = 3'd7;
              if (abort_q)                         eng_d = E_STOP;
              else if (seq_q == S_READ)            begin eng_d = E_RECV; byte_d = 3'd0; end
              else if (byte_q == last_idx(seq_q))  eng_d = E_STOP;
              else begin
                byte_d = byte_q + 3'd1;
                sh_d   = tx_byte(seq_q, byte_q + 3'd1);
                eng_d  = E_SEND;
              end
            end
          endcase
        end
        E_RECV: begin
          case (ph_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: sh_d = {sh_q[6:0], sda_in};
            default: begin
              scl_oe_d = 1'b1;
              if (bit_q == 3'd0) begin eng_d = E_SACK; store = 1'b1; end
              else bit_d = bit_q - 3'd1;
            end
          endcase
        end
        E_SACK: begin
          case (ph_q)
            2'd0: sda_oe_d = (byte_q != 3'd5);  // ACK bytes 0-4, NACK the last
            2'd1: scl_oe_d = 1'b0;
            2'd2: ;
            default: begin
              scl_oe_d = 1'b1;
              if (byte_q == 3'd5) eng_d = E_STOP;
              else begin byte_d = byte_q + 3'd1; bit_d = 3'd7; eng_d = E_RECV; end
            end
          endcase
        end
        E_STOP: begin
          case (ph_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_oe_d = 1'b0;
            default: begin sda_oe_d = 1'b0; eng_d = E_IDLE; busy_d = 1'b0; done = 1'b1; end
          endcase
        end
        default: ;
      endcase
    end

    // Shadow buffer: the fully shifted byte is in sh_q at the last phase.
    if (store) begin
      case (byte_q)
        3'd0: b0_d = sh_q;
        3'd1: b1_d = sh_q;
`ifdef NUNCHUK_ACCEL_EN
        3'd2: b2_d = sh_q;
        3'd3: b3_d = sh_q;
        3'd4: b4_d = sh_q;
        3'd5: begin b5lo_d = sh_q[1:0]; b5hi_d = sh_q[7:2]; end
`else
        3'd5: b5lo_d = sh_q[1:0];
`endif
        default: ;
      endcase
    end

    // Sequencer
    case (seq_q)
      S_RESET, S_GAP_I, S_GAP_P, S_GAP_R: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          launch = 1'b1;
          case (seq_q)
            S_RESET: launch_seq = S_INIT1;
            S_GAP_I: launch_seq = S_INIT2;
            S_GAP_P: launch_seq = S_CONV;
            default: launch_seq = S_READ;
          endcase
        end
      end
      S_INIT1, S_INIT2, S_CONV, S_READ: begin
        if (done) begin
          gap_d   = '0;
          abort_d = 1'b0;
          if (abort_q)              seq_d = S_GAP_I;
          else if (seq_q == S_INIT1) seq_d = S_GAP_I;
          else if (seq_q == S_INIT2) seq_d = S_GAP_P;
          else if (seq_q == S_CONV)  seq_d = S_GAP_R;
          else begin
            // Outputs change together on the edge that enters UPDATE.
            seq_d = S_UPDATE; dv_d = 1'b1; nack_err_d = 1'b0;
            sx_d = b0_q; sy_d = b1_q; z_d = ~b5lo_q[0]; c_d = ~b5lo_q[1];
`ifdef NUNCHUK_ACCEL_EN
            ax_d = {b2_q, b5hi_q[1:0]};
            ay_d = {b3_q, b5hi_q[3:2]};
            az_d = {b4_q, b5hi_q[5:4]};
`endif
          end
        end
      end
      S_UPDATE: begin seq_d = S_GAP_P; gap_d = '0; end
      default: seq_d = S_RESET;
    endcase

    if (launch) begin
      seq_d = launch_seq; eng_d = E_START; busy_d = 1'b1;
      div_d = '0; ph_d = 2'd0; byte_d = 3'd0; bit_d = 3'd7;
      sh_d  = tx_byte(launch_seq, 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= S_RESET; eng_q <= E_IDLE; div_q <= '0; gap_q <= '0;
      ph_q <= 2'd0; bit_q <= 3'd0; byte_q <= 3'd0; sh_q <= 8'd0;
      scl_oe_q <= 1'b0; sda_oe_q <= 1'b0; busy_q <= 1'b0;
      abort_q <= 1'b0; nack_err_q <= 1'b0; dv_q <= 1'b0;
      b0_q <= 8'd0; b1_q <= 8'd0; b5lo_q <= 2'd0;
      sx_q <= 8'd0; sy_q <= 8'd0; z_q <= 1'b0; c_q <= 1'b0;
`ifdef NUNCHUK_ACCEL_EN
      b2_q <= 8'd0; b3_q <= 8'd0; b4_q <= 8'd0; b5hi_q <= 6'd0;
      ax_q <= 10'd0; ay_q <= 10'd0; az_q <= 10'd0;
`endif
    end else begin
      seq_q <= seq_d; eng_q <= eng_d; div_q <= div_d; gap_q <= gap_d;
      ph_q <= ph_d; bit_q <= bit_d; byte_q <= byte_d; sh_q <= sh_d;
      scl_oe_q <= scl_oe_d; sda_oe_q <= sda_oe_d; busy_q <= busy_d;
      abort_q <= abort_d; nack_err_q <= nack_err_d; dv_q <= dv_d;
      b0_q <= b0_d; b1_q <= b1_d; b5lo_q <= b5lo_d;
      sx_q <= sx_d; sy_q <= sy_d; z_q <= z_d; c_q <= c_d;
`ifdef NUNCHUK_ACCEL_EN
      b2_q <= b2_d; b3_q <= b3_d; b4_q <= b4_d; b5hi_q <= b5hi_d;
      ax_q <= ax_d; ay_q <= ay_d; az_q <= az_d;
`endif
    end
  end

  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign nack_err   = nack_err_q;
  assign data_valid = dv_q;
  assign stick_x    = sx_q;
  assign stick_y    = sy_q;
  assign z          = z_q;
  assign c          = c_q;
`ifdef NUNCHUK_ACCEL_EN
  assign accel_x = ax_q;
  assign accel_y = ay_q;
  assign accel_z = az_q;
`else
  assign accel_x = 10'd0;
  assign accel_y = 10'd0;
  assign accel_z = 10'd0;
`endif

endmodule
